// File: rtl/pd_column_render.sv
// rtl/pd_column_render.sv - peak-detect column reader and vertical-run rasterizer
// Optional feature macro: PD_LINK_EN (link each column's span to the previous column's raw pair).
module pd_column_render #(
  parameter int ADDR_W = 10,
  parameter int NCOL   = 1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [15:0]       rd_data_i,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [ADDR_W-1:0] pix_x_o,
  output logic [7:0]        pix_y_o,
  output logic              pix_last_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_EMIT  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NCOL - 1);
  localparam logic [ADDR_W-1:0] COL_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [7:0]        y_q, y_d;
  logic [7:0]        hi_q, hi_d;
  logic              done_q, done_d;

`ifdef PD_LINK_EN
  // Raw (swap-corrected, unlinked) pair of the column being drawn, and of the one before it.
  logic [7:0] raw_lo_q, raw_lo_d;
  logic [7:0] raw_hi_q, raw_hi_d;
  logic [7:0] prev_lo_q, prev_lo_d;
  logic [7:0] prev_hi_q, prev_hi_d;
`endif

  logic [7:0] mem_min, mem_max;
  logic [7:0] sort_lo, sort_hi;
  logic [7:0] span_lo, span_hi;
  logic       at_hi;
  logic       last_col;

  assign mem_max  = rd_data_i[15:8];
  assign mem_min  = rd_data_i[7:0];
  assign at_hi    = (y_q == hi_q);
  assign last_col = (col_q == LAST_COL);

  // Order the fetched pair so the run is always drawn bottom-up, then optionally widen it.
  always_comb begin
    sort_lo = mem_min;
    sort_hi = mem_max;
    if (mem_min > mem_max) begin
      sort_lo = mem_max;
      sort_hi = mem_min;
    end
    span_lo = sort_lo;
    span_hi = sort_hi;
`ifdef PD_LINK_EN
    // Column 0 has no predecessor; later columns stretch to touch the previous raw run.
    if (col_q != '0) begin
      span_lo = (sort_lo < prev_hi_q) ? sort_lo : prev_hi_q;
      span_hi = (sort_hi > prev_lo_q) ? sort_hi : prev_lo_q;
    end
`endif
  end

  // Next-state logic: column walk, pixel counter and end-of-frame pulse.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    y_d     = y_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
`ifdef PD_LINK_EN
    raw_lo_d  = raw_lo_q;
    raw_hi_d  = raw_hi_q;
    prev_lo_d = prev_lo_q;
    prev_hi_d = prev_hi_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
          col_d   = '0;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        y_d     = span_lo;
        hi_d    = span_hi;
`ifdef PD_LINK_EN
        raw_lo_d = sort_lo;
        raw_hi_d = sort_hi;
`endif
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (pix_ready_i) begin
          if (!at_hi) begin
            // y stops at hi, so an 8-bit counter never wraps even for a 0..255 span.
            y_d = y_q + 8'd1;
          end else begin
`ifdef PD_LINK_EN
            prev_lo_d = raw_lo_q;
            prev_hi_d = raw_hi_q;
`endif
            if (last_col) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              col_d   = col_q + COL_ONE;
              state_d = S_FETCH;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a reset mid-frame simply abandons the frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
    end
  end

`ifdef PD_LINK_EN
  // Raw and previous-column pair registers used only for trace linking.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      raw_lo_q  <= '0;
      raw_hi_q  <= '0;
      prev_lo_q <= '0;
      prev_hi_q <= '0;
    end else begin
      raw_lo_q  <= raw_lo_d;
      raw_hi_q  <= raw_hi_d;
      prev_lo_q <= prev_lo_d;
      prev_hi_q <= prev_hi_d;
    end
  end
`endif

  // Outputs are decoded from registered state, so they hold steady while the sink stalls.
  assign busy_o      = (state_q != S_IDLE);
  assign rd_en_o     = (state_q == S_FETCH);
  assign rd_addr_o   = col_q;
  assign pix_valid_o = (state_q == S_EMIT);
  assign pix_x_o     = col_q;
  assign pix_y_o     = y_q;
  assign pix_last_o  = (state_q == S_EMIT) && last_col && at_hi;
  assign done_o      = done_q;

endmodule

// File: tb/tb_pd_column_render.sv
// tb/tb_pd_column_render.sv - randomized self-checking bench for pd_column_render
module tb_pd_column_render;
  localparam int ADDR_W = 10;
  localparam int NCOL   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] pix_x;
  logic [7:0]        pix_y;
  logic              pix_last;
  logic              done;

  pd_column_render #(.ADDR_W(ADDR_W), .NCOL(NCOL)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_x_o(pix_x),
    .pix_y_o(pix_y), .pix_last_o(pix_last), .done_o(done)
  );

  always #5 clk = ~clk;

  // Pair memory with one-cycle read latency; junk on the bus when not reading.
  logic [15:0] mem [NCOL];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr[1:0]];
    else       rd_data <= 16'($urandom);
  end

  int chk_cnt = 0;
  int pass_cnt = 0;

  int exp_x[$], exp_y[$];
  int got_x[$], got_y[$], got_last[$], rd_q[$];
  int first_valid_cyc, last_hs_cyc, done_cyc, done_cnt, stall_err;
  int extra_done, extra_valid, extra_rd;
  bit busy_first, busy_done;

  // Expected pixel list straight from the column rules.
  task automatic build_model();
`ifdef PD_LINK_EN
    int plo, phi;
    plo = 0;
    phi = 0;
`endif
    exp_x.delete();
    exp_y.delete();
    for (int c = 0; c < NCOL; c++) begin
      int a, b, rlo, rhi, lo, hi;
      a = int'(mem[c][15:8]);
      b = int'(mem[c][7:0]);
      rlo = (a < b) ? a : b;
      rhi = (a < b) ? b : a;
      lo = rlo;
      hi = rhi;
`ifdef PD_LINK_EN
      if (c > 0) begin
        lo = (rlo < phi) ? rlo : phi;
        hi = (rhi > plo) ? rhi : plo;
      end
      plo = rlo;
      phi = rhi;
`endif
      for (int y = lo; y <= hi; y++) begin
        exp_x.push_back(c);
        exp_y.push_back(y);
      end
    end
  endtask

  // Drives one frame and records what the DUT emits; mode 0=ready high, 1=toggle, 2=random.
  task automatic run_frame(input int mode, input bit do_start, input int mid_start_at, input bit chain);
    int cyc, vcnt, px, py, pl;
    bit prev_stall, done_seen;
    got_x.delete(); got_y.delete(); got_last.delete(); rd_q.delete();
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1; done_cnt = 0; stall_err = 0;
    extra_done = 0; extra_valid = 0; extra_rd = 0;
    busy_first = 0; busy_done = 1;
    cyc = 0; vcnt = 0; prev_stall = 0; done_seen = 0; px = 0; py = 0; pl = 0;
    if (do_start) begin
      @(negedge clk);
      start = 1;
      @(posedge clk);
    end
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (cyc == 1) busy_first = busy;
      if (rd_en) rd_q.push_back(int'(rd_addr));
      if (done) begin
        done_seen = 1;
        done_cyc = cyc;
        done_cnt++;
        busy_done = busy;
        if (chain) start = 1;
      end
      case (mode)
        0: pix_ready = 1;
        1: pix_ready = (cyc % 2 == 1);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall && (!pix_valid || int'(pix_x) != px || int'(pix_y) != py || int'(pix_last) != pl))
        stall_err++;
      if (pix_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        vcnt++;
        if (vcnt == mid_start_at) start = 1;
        if (pix_ready) begin
          got_x.push_back(int'(pix_x));
          got_y.push_back(int'(pix_y));
          got_last.push_back(int'(pix_last));
          last_hs_cyc = cyc;
        end
      end
      prev_stall = pix_valid && !pix_ready;
      px = int'(pix_x); py = int'(pix_y); pl = int'(pix_last);
    end
    if (chain) begin
      @(posedge clk);
    end else begin
      repeat (4) begin
        @(negedge clk);
        start = 0;
        if (done) extra_done++;
        if (pix_valid) extra_valid++;
        if (rd_en) extra_rd++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; pix_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else pass_cnt++;
    chk_cnt++; if (pix_valid !== 1'b0) $display("FAIL reset_pix_valid: got %b want 0", pix_valid); else pass_cnt++;
    chk_cnt++; if (pix_last !== 1'b0) $display("FAIL reset_pix_last: got %b want 0", pix_last); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    chk_cnt++; if (rd_addr !== '0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); else pass_cnt++;
    chk_cnt++; if (pix_x !== '0) $display("FAIL reset_pix_x: got %0d want 0", pix_x); else pass_cnt++;
    chk_cnt++; if (pix_y !== 8'd0) $display("FAIL reset_pix_y: got %0d want 0", pix_y); else pass_cnt++;
    rst = 0;
  endtask

  task automatic test_basic_raster();
    int errs, bad, n, want_n, want_ly;
    mem[0] = 16'h0503; mem[1] = 16'h0505; mem[2] = 16'h0907; mem[3] = 16'h0200;
    build_model();
    run_frame(0, 1, 0, 0);
`ifdef PD_LINK_EN
    want_n = 17;
    want_ly = 7;
`else
    want_n = 10;
    want_ly = 2;
`endif
    n = got_x.size();
    chk_cnt++; if (n != want_n) $display("FAIL basic_count: got %0d want %0d", n, want_n); else pass_cnt++;
    errs = 0; bad = -1;
    for (int i = 0; i < n && i < exp_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_last[i] != int'(i == exp_x.size() - 1)) begin
        errs++; if (bad < 0) bad = i;
      end
    chk_cnt++; if (errs != 0) $display("FAIL basic_seq: %0d bad pixels, first at %0d, want 0", errs, bad); else pass_cnt++;
    chk_cnt++; if (n > 0 && (got_x[n-1] != 3 || got_y[n-1] != want_ly || got_last[n-1] != 1))
      $display("FAIL basic_last_pixel: got (%0d,%0d,last=%0d) want (3,%0d,last=1)", got_x[n-1], got_y[n-1], got_last[n-1], want_ly);
    else pass_cnt++;
    chk_cnt++; if (first_valid_cyc != 3) $display("FAIL basic_first_latency: got %0d want 3", first_valid_cyc); else pass_cnt++;
    chk_cnt++; if (last_hs_cyc != 2 * NCOL + want_n) $display("FAIL basic_frame_cycles: got %0d want %0d", last_hs_cyc, 2 * NCOL + want_n); else pass_cnt++;
    chk_cnt++; if (done_cyc != last_hs_cyc + 1) $display("FAIL basic_done_timing: got %0d want %0d", done_cyc, last_hs_cyc + 1); else pass_cnt++;
    chk_cnt++; if (done_cnt + extra_done != 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt + extra_done); else pass_cnt++;
    chk_cnt++; if (busy_first != 1 || busy_done != 0) $display("FAIL basic_busy: got first=%0d done=%0d want 1/0", busy_first, busy_done); else pass_cnt++;
    chk_cnt++; if (rd_q.size() != NCOL || rd_q[0] != 0 || rd_q[1] != 1 || rd_q[2] != 2 || rd_q[3] != 3)
      $display("FAIL basic_rd_addr: got %0d reads want 4 at 0..3", rd_q.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int errs, n;
    mem[0] = 16'h0503; mem[1] = 16'h0505; mem[2] = 16'h0907; mem[3] = 16'h0200;
    build_model();
    run_frame(1, 1, 0, 0);
    n = got_x.size();
    chk_cnt++; if (n != exp_x.size()) $display("FAIL bp_count: got %0d want %0d", n, exp_x.size()); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < n && i < exp_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_last[i] != int'(i == exp_x.size() - 1)) errs++;
    chk_cnt++; if (errs != 0) $display("FAIL bp_seq: got %0d bad pixels want 0", errs); else pass_cnt++;
    chk_cnt++; if (stall_err != 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_swap_full();
    int errs, n, c0, c1, c1_first, c1_last;
    mem[0] = 16'h0206; mem[1] = 16'hFF00;
    mem[2] = 16'($urandom); mem[3] = 16'($urandom);
    build_model();
    run_frame(2, 1, 0, 0);
    n = got_x.size();
    c0 = 0; c1 = 0; c1_first = -1; c1_last = -1; errs = 0;
    for (int i = 0; i < n; i++) begin
      if (got_x[i] == 0) begin
        if (got_y[i] != 2 + c0) errs++;
        c0++;
      end
      if (got_x[i] == 1) begin
        if (got_y[i] != c1) errs++;
        if (c1_first < 0) c1_first = got_y[i];
        c1_last = got_y[i];
        c1++;
      end
    end
    chk_cnt++; if (c0 != 5) $display("FAIL swap_count: got %0d want 5", c0); else pass_cnt++;
    chk_cnt++; if (c1 != 256) $display("FAIL full_count: got %0d want 256", c1); else pass_cnt++;
    chk_cnt++; if (c1_first != 0 || c1_last != 255) $display("FAIL full_ends: got %0d..%0d want 0..255", c1_first, c1_last); else pass_cnt++;
    chk_cnt++; if (errs != 0) $display("FAIL swap_full_order: got %0d bad pixels want 0", errs); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < n && i < exp_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) errs++;
    chk_cnt++; if (n != exp_x.size() || errs != 0) $display("FAIL swap_full_seq: got %0d pixels %0d bad want %0d/0", n, errs, exp_x.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int waited, dn, errs;
    for (int c = 0; c < NCOL; c++) mem[c] = 16'($urandom);
    build_model();
    @(negedge clk); start = 1; pix_ready = 1;
    @(posedge clk);
    waited = 0;
    do begin
      @(negedge clk); start = 0; waited++;
    end while (!(pix_valid && pix_x == 1) && waited < 1000);
    chk_cnt++; if (waited >= 1000) $display("FAIL rst_mid_reach_x1: got timeout want EMIT of x1"); else pass_cnt++;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk_cnt++; if (pix_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_idle: got valid=%b busy=%b want 0/0", pix_valid, busy); else pass_cnt++;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk_cnt++; if (dn != 0) $display("FAIL rst_mid_no_done: got %0d want 0", dn); else pass_cnt++;
    run_frame(0, 1, 0, 0);
    chk_cnt++; if (rd_q.size() == 0 || rd_q[0] != 0) $display("FAIL rst_restart_addr: got %0d want 0", rd_q.size() ? rd_q[0] : -1); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) errs++;
    chk_cnt++; if (got_x.size() != exp_x.size() || errs != 0) $display("FAIL rst_restart_seq: got %0d pixels %0d bad want %0d/0", got_x.size(), errs, exp_x.size()); else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int errs;
    for (int c = 0; c < NCOL; c++) mem[c] = 16'($urandom);
    build_model();
    run_frame(0, 1, 3, 0);
    errs = 0;
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) errs++;
    chk_cnt++; if (got_x.size() != exp_x.size() || errs != 0) $display("FAIL busy_start_seq: got %0d pixels %0d bad want %0d/0", got_x.size(), errs, exp_x.size()); else pass_cnt++;
    chk_cnt++; if (done_cnt + extra_done != 1) $display("FAIL busy_start_done: got %0d want 1", done_cnt + extra_done); else pass_cnt++;
    chk_cnt++; if (extra_valid + extra_rd != 0) $display("FAIL busy_start_no_refetch: got %0d want 0", extra_valid + extra_rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int errs;
    for (int c = 0; c < NCOL; c++) mem[c] = 16'($urandom);
    build_model();
    run_frame(0, 1, 0, 1);
    chk_cnt++; if (done_cnt != 1) $display("FAIL b2b_first_done: got %0d want 1", done_cnt); else pass_cnt++;
    run_frame(2, 0, 0, 0);
    chk_cnt++; if (busy_first != 1) $display("FAIL b2b_busy: got %0d want 1", busy_first); else pass_cnt++;
    chk_cnt++; if (rd_q.size() == 0 || rd_q[0] != 0) $display("FAIL b2b_rd_addr: got %0d reads want first at 0", rd_q.size()); else pass_cnt++;
    errs = 0;
    for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) errs++;
    chk_cnt++; if (got_x.size() != exp_x.size() || errs != 0) $display("FAIL b2b_seq: got %0d pixels %0d bad want %0d/0", got_x.size(), errs, exp_x.size()); else pass_cnt++;
    chk_cnt++; if (done_cnt != 1) $display("FAIL b2b_second_done: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_random_frames();
    int errs;
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < NCOL; c++) mem[c] = 16'($urandom);
      build_model();
      run_frame(2, 1, 0, 0);
      errs = 0;
      for (int i = 0; i < got_x.size() && i < exp_x.size(); i++)
        if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i] || got_last[i] != int'(i == exp_x.size() - 1)) errs++;
      chk_cnt++; if (got_x.size() != exp_x.size() || errs != 0)
        $display("FAIL rand_seq[%0d]: got %0d pixels %0d bad want %0d/0", f, got_x.size(), errs, exp_x.size());
      else pass_cnt++;
      chk_cnt++; if (stall_err != 0 || done_cnt != 1)
        $display("FAIL rand_protocol[%0d]: got stalls=%0d done=%0d want 0/1", f, stall_err, done_cnt);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_raster();
    test_backpressure();
    test_swap_full();
    test_reset_mid_frame();
    test_start_while_busy();
    test_back_to_back();
    test_random_frames();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
